// File: rtl/branch_flag_unit_if.sv
// ALU-status / branch-request bundle between the pipeline and branch_flag_unit.
interface branch_flag_unit_if #(
  parameter int W = 8,
  parameter int A = 10
);
  logic         Stall;
  logic         FlagWrEn;
  logic         CarryWrEn;
  logic         CarryClr;
  logic         AluZero;
  logic         AluNeg;
  logic         AluOdd;
  logic         AluParity;
  logic         AluSC;
  logic         BranchReq;
  logic [2:0]   BranchCond;
  logic [W-1:0] BranchOffset;
  logic [A-1:0] PC;

  logic         SC_in;
  logic         Zero_q;
  logic         Neg_q;
  logic         Carry_q;
  logic         Odd_q;
  logic         Parity_q;
  logic         Taken;
  logic [A-1:0] Target;
  logic         Flush;

  modport master (
    output Stall, FlagWrEn, CarryWrEn, CarryClr,
           AluZero, AluNeg, AluOdd, AluParity, AluSC,
           BranchReq, BranchCond, BranchOffset, PC,
    input  SC_in, Zero_q, Neg_q, Carry_q, Odd_q, Parity_q,
           Taken, Target, Flush
  );

  modport slave (
    input  Stall, FlagWrEn, CarryWrEn, CarryClr,
           AluZero, AluNeg, AluOdd, AluParity, AluSC,
           BranchReq, BranchCond, BranchOffset, PC,
    output SC_in, Zero_q, Neg_q, Carry_q, Odd_q, Parity_q,
           Taken, Target, Flush
  );
endinterface

// File: rtl/branch_flag_unit.sv
// Registered ALU status flags, carry feedback for multi-byte chains, and
// conditional branch resolution with a fixed-length pipeline flush.
module branch_flag_unit #(
  parameter int W         = 8,
  parameter int A         = 10,
  parameter int FLUSH_CYC = 2
) (
  input logic              Clk,
  input logic              Reset_n,
  branch_flag_unit_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t       state_q;
  logic [2:0]   cnt_q;
  logic         taken_q;
  logic [A-1:0] target_q;

  logic zero_q, neg_q, carry_q, odd_q, parity_q;
  logic zero_d, neg_d, carry_d, odd_d, parity_d;

  logic         wr_ok;
  logic         accept;
  logic         eff_z, eff_n, eff_c;
  logic         cond_true;
  logic [A-1:0] off_ext;
  logic [A-1:0] target_d;

  // Write/accept gating plus forwarded flag values for same-cycle compare+branch
  always_comb begin
    wr_ok    = !bus.Stall && (state_q == IDLE);
    accept   = wr_ok && bus.BranchReq;
    eff_z    = bus.FlagWrEn ? bus.AluZero : zero_q;
    eff_n    = bus.FlagWrEn ? bus.AluNeg  : neg_q;
    if (bus.CarryWrEn)     eff_c = bus.AluSC;
    else if (bus.CarryClr) eff_c = 1'b0;
    else                   eff_c = carry_q;
    off_ext  = {{(A-W){bus.BranchOffset[W-1]}}, bus.BranchOffset};
    target_d = bus.PC + off_ext;
  end

  // Condition-code decode against the effective flags
  always_comb begin
    cond_true = 1'b0;
    case (bus.BranchCond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = eff_z;
      3'b010:  cond_true = !eff_z;
      3'b011:  cond_true = eff_n;
      3'b100:  cond_true = !eff_n;
      3'b101:  cond_true = eff_c;
      3'b110:  cond_true = !eff_c;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state flags; writes are squashed while stalled or flushing
  always_comb begin
    zero_d   = zero_q;
    neg_d    = neg_q;
    odd_d    = odd_q;
    parity_d = parity_q;
    carry_d  = carry_q;
    if (wr_ok && bus.FlagWrEn) begin
      zero_d   = bus.AluZero;
      neg_d    = bus.AluNeg;
      odd_d    = bus.AluOdd;
      parity_d = bus.AluParity;
    end
    if (wr_ok && (bus.CarryWrEn || bus.CarryClr))
      carry_d = bus.CarryWrEn ? bus.AluSC : 1'b0;
  end

  // Flag registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      odd_q    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      odd_q    <= odd_d;
      parity_q <= parity_d;
    end
  end

  // Branch/flush FSM with registered Taken, Target and flush counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (bus.Stall) begin
      taken_q <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && cond_true) begin
            taken_q  <= 1'b1;
            target_q <= target_d;
            state_q  <= FLUSH;
            cnt_q    <= 3'(FLUSH_CYC);
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Zero_q   = zero_q;
  assign bus.Neg_q    = neg_q;
  assign bus.Carry_q  = carry_q;
  assign bus.Odd_q    = odd_q;
  assign bus.Parity_q = parity_q;
  assign bus.SC_in    = carry_q;
  assign bus.Taken    = taken_q;
  assign bus.Target   = target_q;
  assign bus.Flush    = (state_q == FLUSH);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: reset, compare+branch, forwarding,
// carry chain, wrong-path squash and stall.
module tb_branch_flag_unit;
  localparam int W = 8;
  localparam int A = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  branch_flag_unit_if #(.W(W), .A(A)) bus ();

  branch_flag_unit #(.W(W), .A(A), .FLUSH_CYC(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [4:0] flags;
  assign flags = {bus.Zero_q, bus.Neg_q, bus.Carry_q, bus.Odd_q, bus.Parity_q};

  task automatic idle_inputs();
    bus.Stall = 0; bus.FlagWrEn = 0; bus.CarryWrEn = 0; bus.CarryClr = 0;
    bus.AluZero = 0; bus.AluNeg = 0; bus.AluOdd = 0; bus.AluParity = 0; bus.AluSC = 0;
    bus.BranchReq = 0; bus.BranchCond = 3'b000; bus.BranchOffset = '0; bus.PC = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic branch(input logic [2:0] c, input logic [A-1:0] pc, input logic [W-1:0] off);
    bus.BranchReq = 1; bus.BranchCond = c; bus.PC = pc; bus.BranchOffset = off;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_n = 0;
    tick();
    Reset_n = 1;
    tick();
    bus.FlagWrEn = 1; bus.AluZero = 1; bus.AluNeg = 1; bus.AluOdd = 1; bus.AluParity = 1;
    bus.CarryWrEn = 1; bus.AluSC = 1;
    branch(3'b000, 10'h005, 8'h01);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Flush !== 1'b1 || bus.Target !== 10'h006) begin errors++;
      $display("FAIL reset_pre: Taken=%b Flush=%b Target=%h want 1 1 006", bus.Taken, bus.Flush, bus.Target); end
    checks++; if (flags !== 5'b11111 || bus.SC_in !== 1'b1) begin errors++;
      $display("FAIL reset_pre_flags: flags=%b SC_in=%b want 11111 1", flags, bus.SC_in); end
    idle_inputs();
    #2 Reset_n = 0;
    #1;
    checks++; if (bus.Taken !== 1'b0 || bus.Flush !== 1'b0 || bus.Target !== 10'h000) begin errors++;
      $display("FAIL reset_async: Taken=%b Flush=%b Target=%h want 0 0 000", bus.Taken, bus.Flush, bus.Target); end
    checks++; if (flags !== 5'b00000 || bus.SC_in !== 1'b0) begin errors++;
      $display("FAIL reset_async_flags: flags=%b SC_in=%b want 00000 0", flags, bus.SC_in); end
    tick();
    Reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({flags, bus.SC_in, bus.Taken, bus.Flush} !== 8'h00 || bus.Target !== 10'h000) begin errors++;
        $display("FAIL reset_idle%0d: flags=%b SC=%b T=%b F=%b Tgt=%h want all 0", i, flags, bus.SC_in, bus.Taken, bus.Flush, bus.Target); end
    end
  endtask

  task automatic test_cmp_eq();
    idle_inputs();
    bus.FlagWrEn = 1; bus.AluZero = 1;
    tick();
    checks++; if (flags !== 5'b10000) begin errors++;
      $display("FAIL cmp_flags: flags=%b want 10000", flags); end
    idle_inputs();
    branch(3'b001, 10'h010, 8'hFC);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h00C || bus.Flush !== 1'b1) begin errors++;
      $display("FAIL eq_taken: Taken=%b Target=%h Flush=%b want 1 00C 1", bus.Taken, bus.Target, bus.Flush); end
    idle_inputs();
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Flush !== 1'b1 || bus.Target !== 10'h00C) begin errors++;
      $display("FAIL eq_flush2: Taken=%b Flush=%b Target=%h want 0 1 00C", bus.Taken, bus.Flush, bus.Target); end
    tick();
    checks++; if (bus.Flush !== 1'b0) begin errors++;
      $display("FAIL eq_flush_end: Flush=%b want 0", bus.Flush); end
  endtask

  task automatic test_forward();
    idle_inputs();
    bus.FlagWrEn = 1; bus.AluNeg = 1;
    branch(3'b011, 10'h3FE, 8'h05);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h003 || bus.Neg_q !== 1'b1) begin errors++;
      $display("FAIL fwd_lt: Taken=%b Target=%h Neg_q=%b want 1 003 1", bus.Taken, bus.Target, bus.Neg_q); end
    idle_inputs();
    tick(); tick();
    // Registered Neg=1 but incoming Neg=0: LT must not be taken
    bus.FlagWrEn = 1; bus.AluNeg = 0;
    branch(3'b011, 10'h100, 8'h20);
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Target !== 10'h003 || bus.Neg_q !== 1'b0) begin errors++;
      $display("FAIL fwd_lt_false: Taken=%b Target=%h Neg_q=%b want 0 003 0", bus.Taken, bus.Target, bus.Neg_q); end
  endtask

  task automatic test_carry();
    idle_inputs();
    bus.CarryClr = 1;
    tick();
    checks++; if (bus.SC_in !== 1'b0) begin errors++; $display("FAIL carry_clr: SC_in=%b want 0", bus.SC_in); end
    idle_inputs();
    bus.CarryWrEn = 1; bus.AluSC = 1;
    tick();
    checks++; if (bus.SC_in !== 1'b1 || bus.Carry_q !== 1'b1) begin errors++;
      $display("FAIL carry_wr: SC_in=%b Carry_q=%b want 1 1", bus.SC_in, bus.Carry_q); end
    bus.CarryWrEn = 1; bus.CarryClr = 1; bus.AluSC = 0;
    tick();
    checks++; if (bus.SC_in !== 1'b0) begin errors++; $display("FAIL carry_both0: SC_in=%b want 0", bus.SC_in); end
    bus.AluSC = 1;
    tick();
    checks++; if (bus.SC_in !== 1'b1) begin errors++; $display("FAIL carry_both1: SC_in=%b want 1", bus.SC_in); end
    // Carry_q=1 but CarryClr in the branch cycle forwards 0: CS not taken
    idle_inputs();
    bus.CarryClr = 1;
    branch(3'b101, 10'h040, 8'h10);
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.SC_in !== 1'b0) begin errors++;
      $display("FAIL carry_fwd_cs: Taken=%b SC_in=%b want 0 0", bus.Taken, bus.SC_in); end
    idle_inputs();
    branch(3'b110, 10'h040, 8'h10);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h050) begin errors++;
      $display("FAIL carry_cc: Taken=%b Target=%h want 1 050", bus.Taken, bus.Target); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_squash();
    idle_inputs();
    bus.FlagWrEn = 1; bus.AluZero = 1;
    tick();
    idle_inputs();
    branch(3'b000, 10'h100, 8'h10);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h110) begin errors++;
      $display("FAIL squash_first: Taken=%b Target=%h want 1 110", bus.Taken, bus.Target); end
    branch(3'b000, 10'h200, 8'h00);
    bus.FlagWrEn = 1; bus.AluZero = 0;
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Zero_q !== 1'b1 || bus.Flush !== 1'b1 || bus.Target !== 10'h110) begin errors++;
      $display("FAIL squash_1: Taken=%b Zero_q=%b Flush=%b Target=%h want 0 1 1 110", bus.Taken, bus.Zero_q, bus.Flush, bus.Target); end
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Zero_q !== 1'b1 || bus.Flush !== 1'b0) begin errors++;
      $display("FAIL squash_2: Taken=%b Zero_q=%b Flush=%b want 0 1 0", bus.Taken, bus.Zero_q, bus.Flush); end
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h200 || bus.Zero_q !== 1'b0) begin errors++;
      $display("FAIL squash_after: Taken=%b Target=%h Zero_q=%b want 1 200 0", bus.Taken, bus.Target, bus.Zero_q); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_stall();
    idle_inputs();
    branch(3'b111, 10'h020, 8'h80);
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Target !== 10'h200) begin errors++;
      $display("FAIL never: Taken=%b Target=%h want 0 200", bus.Taken, bus.Target); end
    branch(3'b000, 10'h020, 8'h80);
    tick();
    checks++; if (bus.Taken !== 1'b1 || bus.Target !== 10'h3A0 || bus.Flush !== 1'b1) begin errors++;
      $display("FAIL stall_br: Taken=%b Target=%h Flush=%b want 1 3A0 1", bus.Taken, bus.Target, bus.Flush); end
    bus.Stall = 1; bus.FlagWrEn = 1; bus.AluZero = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.Taken !== 1'b0 || bus.Flush !== 1'b1 || bus.Zero_q !== 1'b0 || bus.Target !== 10'h3A0) begin errors++;
        $display("FAIL stall_%0d: Taken=%b Flush=%b Zero_q=%b Target=%h want 0 1 0 3A0", i, bus.Taken, bus.Flush, bus.Zero_q, bus.Target); end
    end
    idle_inputs();
    tick();
    checks++; if (bus.Flush !== 1'b1 || bus.Taken !== 1'b0) begin errors++;
      $display("FAIL stall_resume: Flush=%b Taken=%b want 1 0", bus.Flush, bus.Taken); end
    tick();
    checks++; if (bus.Flush !== 1'b0) begin errors++; $display("FAIL stall_done: Flush=%b want 0", bus.Flush); end
    // Stall outside flush blocks an always-taken request
    bus.Stall = 1;
    branch(3'b000, 10'h001, 8'h01);
    tick();
    checks++; if (bus.Taken !== 1'b0 || bus.Flush !== 1'b0 || bus.Target !== 10'h3A0) begin errors++;
      $display("FAIL stall_idle: Taken=%b Flush=%b Target=%h want 0 0 3A0", bus.Taken, bus.Flush, bus.Target); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cmp_eq();
    test_forward();
    test_carry();
    test_squash();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Sequential consumer of the combinational ALU's status outputs.
- Registers the Zero, Neg, Carry, Odd and Parity flags from flag-setting ops (CMP, ADD, LSH).
- Feeds the registered carry back to the ALU as SC_in for multi-byte add/shift chains.
- Resolves conditional branches against the flags, producing a registered taken pulse, a PC-relative target and a fixed-length pipeline flush.

Parameters:
- W, 8, ALU data width; BranchOffset width.
- A, 10, program-counter width.
- FLUSH_CYC, 2, number of cycles Flush is held after a taken branch (range 1..7).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Stall  in  1  global stall: all state holds, requests ignored.
- FlagWrEn  in  1  latch Zero/Neg/Odd/Parity from the ALU this cycle.
- CarryWrEn  in  1  latch carry from AluSC this cycle.
- CarryClr  in  1  clear carry (start of a multi-byte chain).
- AluZero, AluNeg, AluOdd, AluParity, AluSC  in  1 each  ALU status outputs, same cycle.
- BranchReq  in  1  current instruction is a conditional branch.
- BranchCond  in  3  condition code.
- BranchOffset  in  W  signed two's-complement PC offset.
- PC  in  A  PC of the branch instruction.
- SC_in  out  1  registered carry to the ALU (equals Carry_q).
- Zero_q, Neg_q, Carry_q, Odd_q, Parity_q  out  1 each  registered flags.
- Taken  out  1  one-cycle pulse: branch taken.
- Target  out  A  branch target, valid while Taken=1.
- Flush  out  1  squash younger instructions.

Behaviour:
- Reset (async, Reset_n=0): all flags 0, SC_in 0, Taken 0, Target 0, Flush 0, flush counter 0. Reset asserted mid-flush or mid-chain aborts immediately; there is no pending state after release.
- Stall=1: no register changes. Taken is forced 0 and Target holds. The flush counter and Flush hold their values.
- Flag write: on a clock edge with FlagWrEn=1, Stall=0, Flush=0, the Zero/Neg/Odd/Parity flags take the ALU values.
- Carry write: CarryWrEn=1 loads AluSC. CarryClr=1 loads 0. If both are high, CarryWrEn wins. Carry gating (Stall, Flush) is the same as for the flag write.
- Condition codes, evaluated on effective flags: 000 always; 001 EQ (Z); 010 NE (!Z); 011 LT (N); 100 GE (!N); 101 CS (C); 110 CC (!C); 111 never.
- Effective flags (forwarding): when FlagWrEn and BranchReq are high in the same cycle, the condition uses the incoming Alu* values rather than the registered ones. The same rule applies to carry with CarryWrEn (CarryClr → 0).
- Branch resolution, latency 1:
  - BranchReq=1, Stall=0, Flush=0 at edge t with the condition true → Taken=1 in cycle t+1 for exactly one cycle.
  - Target = PC + sign_extend(BranchOffset), computed modulo 2^A (wraps silently), registered at the same edge.
  - When the condition is false: Taken=0 and Target holds its previous value.
- Flush FSM:
  - States IDLE and FLUSH, with a 3-bit counter.
  - A taken branch at edge t enters FLUSH with the counter at FLUSH_CYC. Flush=1 from cycle t+1 through cycle t+FLUSH_CYC.
  - The counter decrements each unstalled edge; reaching 0 returns to IDLE.
  - While Flush=1, BranchReq, FlagWrEn, CarryWrEn and CarryClr are ignored (wrong-path squash).
- Back-to-back branches: the second is accepted only once Flush has deasserted.
- Outputs Zero_q/Neg_q/Carry_q/Odd_q/Parity_q/SC_in are direct register outputs with no combinational path from inputs. Taken/Target/Flush are also registered.

Test Plan:
- Reset: drive Reset_n=0 asynchronously mid-cycle while Flush=1 → all outputs 0 immediately. Release, then idle 3 cycles → outputs remain 0.
- CMP then branch EQ: FlagWrEn=1 with AluZero=1, next cycle BranchReq, Cond=001, PC=0x010, Offset=0xFC → Taken=1 for one cycle, Target=0x00C, Flush=1 for exactly 2 cycles.
- Forwarding: same-cycle FlagWrEn=1 with AluNeg=1, BranchReq, Cond=011, PC=0x3FE, Offset=0x05 → Taken=1, Target=0x003 (wrap).
- Carry chain: CarryClr → SC_in=0. Then CarryWrEn with AluSC=1 → SC_in=1 next cycle. Then CarryWrEn+CarryClr both high with AluSC=0 → SC_in=0; both high with AluSC=1 → SC_in=1.
- Squash: a taken branch, then during Flush assert BranchReq Cond=000 and FlagWrEn with AluZero=0 → no second Taken, Zero_q unchanged. The first request after Flush drops is accepted.
- Stall: assert Stall for 3 cycles during Flush and with BranchReq=1 → Flush length extends by 3, Taken stays 0, flags hold. Deassert → normal completion.
